// File: rtl/mk_watchdog.sv
// Watchdog for the companion MK: expects rising edges on event_mk and pulses the
// MK's active-low reset when they stop. A high boot0 suspends supervision.
module mk_watchdog #(
   parameter int unsigned TIMEOUT_CYC      = 1_250_000,
   parameter int unsigned BOOT_TIMEOUT_CYC = 2_500_000,
   parameter int unsigned RST_PULSE_CYC    = 12_500
) (
   input  logic       clk,
   input  logic       srstb,
   input  logic       event_mk,
   input  logic       boot0,
   output logic       rst_n,
   output logic [7:0] fire_cnt
);

   localparam int unsigned MAX_AB  = (TIMEOUT_CYC > BOOT_TIMEOUT_CYC) ? TIMEOUT_CYC : BOOT_TIMEOUT_CYC;
   localparam int unsigned MAX_CYC = (MAX_AB > RST_PULSE_CYC) ? MAX_AB : RST_PULSE_CYC;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

   localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(BOOT_TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] FIRE_LAST = CNT_W'(RST_PULSE_CYC - 1);

   typedef enum logic [1:0] {ARM, RUN, FIRE, BOOT} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             rst_n_nxt;
   logic [7:0]       fire_cnt_nxt;

   logic ev_meta, ev_sync, ev_prev;
   logic boot_meta, boot_sync;
   logic kick;

   assign kick = ev_sync & ~ev_prev;

   always_ff @(posedge clk or negedge srstb) begin
      if (!srstb) begin
         ev_meta   <= 1'b0;
         ev_sync   <= 1'b0;
         ev_prev   <= 1'b0;
         boot_meta <= 1'b0;
         boot_sync <= 1'b0;
         state     <= ARM;
         cnt       <= '0;
         rst_n     <= 1'b1;
         fire_cnt  <= '0;
      end else begin
         ev_meta   <= event_mk;
         ev_sync   <= ev_meta;
         ev_prev   <= ev_sync;
         boot_meta <= boot0;
         boot_sync <= boot_meta;
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         rst_n     <= rst_n_nxt;
         fire_cnt  <= fire_cnt_nxt;
      end
   end

   // Priority: boot0, then kick, then timeout; counter clears on every transition.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CNT_W'(1);
      if (boot_sync) begin
         state_nxt = BOOT;
         cnt_nxt   = '0;
      end else begin
         case (state)
            ARM: begin
               if (kick) begin
                  state_nxt = RUN;
                  cnt_nxt   = '0;
               end else if (cnt == ARM_LAST) begin
                  state_nxt = FIRE;
                  cnt_nxt   = '0;
               end
            end
            RUN: begin
               if (kick) begin
                  cnt_nxt = '0;
               end else if (cnt == RUN_LAST) begin
                  state_nxt = FIRE;
                  cnt_nxt   = '0;
               end
            end
            FIRE: begin
               if (cnt == FIRE_LAST) begin
                  state_nxt = ARM;
                  cnt_nxt   = '0;
               end
            end
            BOOT: begin
               state_nxt = ARM;
               cnt_nxt   = '0;
            end
            default: begin
               state_nxt = ARM;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // rst_n follows the registered state, so the low pulse spans the FIRE cycles one edge late.
   always_comb begin
      rst_n_nxt    = (state != FIRE);
      fire_cnt_nxt = fire_cnt;
      if (state_nxt == FIRE && state != FIRE && fire_cnt != 8'hFF) begin
         fire_cnt_nxt = fire_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_mk_watchdog.sv
// Directed bench for mk_watchdog with shortened timeouts (1000/2000/100 cycles).
module tb_mk_watchdog;

   logic       clk = 1'b0;
   logic       srstb;
   logic       event_mk;
   logic       boot0;
   logic       rst_n;
   logic [7:0] fire_cnt;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned n;
   int unsigned lows;

   mk_watchdog #(
      .TIMEOUT_CYC      (1000),
      .BOOT_TIMEOUT_CYC (2000),
      .RST_PULSE_CYC    (100)
   ) dut (
      .clk      (clk),
      .srstb    (srstb),
      .event_mk (event_mk),
      .boot0    (boot0),
      .rst_n    (rst_n),
      .fire_cnt (fire_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int unsigned k);
      repeat (k) @(negedge clk);
   endtask

   // Counts negedges until rst_n equals lvl (bounded by max); drops event_mk at count drop_at.
   task automatic time_to(input logic lvl, input int unsigned max, input int unsigned drop_at,
                          output int unsigned cnt);
      cnt = 0;
      while (rst_n !== lvl && cnt < max) begin
         @(negedge clk);
         cnt++;
         if (cnt == drop_at) event_mk = 1'b0;
      end
   endtask

   task automatic do_reset();
      srstb = 1'b0;
      cyc(3);
      srstb = 1'b1;
   endtask

   initial begin
      srstb    = 1'b0;
      event_mk = 1'b0;
      boot0    = 1'b0;
      cyc(3);
      check("reset_rst_n", 32'(rst_n), 1);
      check("reset_fire_cnt", 32'(fire_cnt), 0);
      srstb = 1'b1;

      // No kicks: fire after 2000 cycles of ARM, 100-cycle pulse, repeats every 2100
      time_to(1'b0, 3000, 0, n);
      check("arm_first_fire", n, 2001);
      check("fire_cnt_1", 32'(fire_cnt), 1);
      time_to(1'b1, 300, 0, n);
      check("pulse_width", n, 100);
      time_to(1'b0, 3000, 0, n);
      check("arm_refire", n, 2000);
      check("fire_cnt_2", 32'(fire_cnt), 2);
      time_to(1'b1, 300, 0, n);
      check("pulse_width_2", n, 100);

      // Periodic kicks: long first pulse, then 1-cycle pulses every 900 cycles
      do_reset();
      cyc(125);
      lows = 0;
      for (int unsigned c = 0; c < 18500; c++) begin
         event_mk = (c < 100) || (c >= 900 && (c % 900) == 0);
         @(negedge clk);
         if (rst_n === 1'b0) lows++;
      end
      event_mk = 1'b0;
      check("periodic_no_low", lows, 0);
      check("periodic_fire_cnt", 32'(fire_cnt), 0);

      // Long-high kick: timeout measured from the rising edge
      do_reset();
      cyc(10);
      event_mk = 1'b1;
      time_to(1'b0, 3000, 100, n);
      check("long_kick_lat", n, 1004);
      check("long_kick_fire_cnt", 32'(fire_cnt), 1);
      cyc(40);
      event_mk = 1'b1;
      time_to(1'b1, 200, 1, n);
      check("fire_ignores_kick", n, 60);
      // Back in ARM: kick A, then kick B landing exactly on the RUN timeout edge
      event_mk = 1'b1;
      cyc(1);
      event_mk = 1'b0;
      cyc(999);
      event_mk = 1'b1;
      time_to(1'b0, 3000, 1, n);
      check("boundary_kick_lat", n, 1004);
      check("boundary_fire_cnt", 32'(fire_cnt), 2);

      // boot0 asserted mid-RUN
      do_reset();
      event_mk = 1'b1;
      cyc(1);
      event_mk = 1'b0;
      cyc(400);
      boot0 = 1'b1;
      lows = 0;
      for (int unsigned c = 0; c < 8000; c++) begin
         @(negedge clk);
         if (rst_n === 1'b0) lows++;
      end
      check("boot_run_no_low", lows, 0);
      check("boot_run_fire_cnt", 32'(fire_cnt), 0);
      boot0 = 1'b0;
      time_to(1'b0, 3000, 0, n);
      check("boot_release_lat", n, 2004);
      check("boot_release_fire_cnt", 32'(fire_cnt), 1);

      // boot0 asserted mid-FIRE aborts the pulse
      cyc(50);
      boot0 = 1'b1;
      time_to(1'b1, 20, 0, n);
      check("boot_abort_lat", n, 4);
      lows = 0;
      for (int unsigned c = n; c < 8000; c++) begin
         @(negedge clk);
         if (rst_n === 1'b0) lows++;
      end
      check("boot_fire_no_low", lows, 0);
      check("boot_fire_fire_cnt", 32'(fire_cnt), 1);
      boot0 = 1'b0;
      time_to(1'b0, 3000, 0, n);
      check("boot_release_lat_2", n, 2004);
      check("boot_release_fire_cnt_2", 32'(fire_cnt), 2);

      // Async reset mid-FIRE
      cyc(20);
      #2;
      srstb = 1'b0;
      #1;
      check("async_rst_n", 32'(rst_n), 1);
      check("async_fire_cnt", 32'(fire_cnt), 0);
      cyc(3);
      srstb = 1'b1;
      time_to(1'b0, 3000, 0, n);
      check("post_reset_arm_lat", n, 2001);
      check("post_reset_fire_cnt", 32'(fire_cnt), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
